// File: rtl/iomem_pwm_pkg.sv
// Shared register map and helpers for the iomem PWM/GPIO peripheral.
// Optional polarity register is controlled by IOMEM_PWM_POLARITY_EN.
package iomem_pwm_pkg;

  localparam logic [5:0] REG_CTRL  = 6'h00;
  localparam logic [5:0] REG_PRESC = 6'h01;
  localparam logic [5:0] REG_GPIO  = 6'h02;
  localparam logic [5:0] REG_POL   = 6'h03;
  localparam logic [5:0] REG_DUTY0 = 6'h04;

  localparam int CTRL_EN_BIT = 0;
  localparam int NUM_CH_MAX  = 32;

  // Expands the four byte strobes into a 32-bit write mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/iomem_pwm_gpio_channel.sv
// One PWM channel: shadow/active duty pair, compare and registered output.
// The pol input only exists when IOMEM_PWM_POLARITY_EN is defined.
module pwm_channel #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             wrap,
  input  logic             duty_we,
  input  logic [PWM_W:0]   duty_wdata,
  input  logic [PWM_W-1:0] cnt,
  input  logic             gpio,
`ifdef IOMEM_PWM_POLARITY_EN
  input  logic             pol,
`endif
  output logic [PWM_W:0]   duty_sh,
  output logic             pwm_out
);

  logic [PWM_W:0] duty_act;
  logic           level;

  assign level = en ? ({1'b0, cnt} < duty_act) : gpio;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm_out  <= 1'b0;
    end else begin
      if (duty_we)
        duty_sh <= duty_wdata;
      // A write landing on the wrap edge stays in shadow until the next wrap.
      if (!en || wrap)
        duty_act <= duty_sh;
`ifdef IOMEM_PWM_POLARITY_EN
      pwm_out <= level ^ pol;
`else
      pwm_out <= level;
`endif
    end
  end

endmodule

// File: rtl/iomem_pwm_gpio.sv
// Memory-mapped GPIO/PWM peripheral on the ricosoc iomem bus.
// Define IOMEM_PWM_POLARITY_EN to add the POL register at offset 0x0C.
module iomem_pwm_gpio
  import iomem_pwm_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          PWM_W     = 8,
  parameter int          PRESC_W   = 16,
  parameter logic [7:0]  BASE_ADDR = 8'h03
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic [NUM_CH-1:0] pwm_out
);

  logic               en;
  logic [PRESC_W-1:0] presc;
  logic [NUM_CH-1:0]  gpio;
`ifdef IOMEM_PWM_POLARITY_EN
  logic [NUM_CH-1:0]  pol;
`endif
  logic [PRESC_W-1:0] presc_cnt;
  logic [PWM_W-1:0]   cnt;
  logic               tick;
  logic               wrap;

  logic               accept;
  logic               wr_acc;
  logic [5:0]         word;
  logic [31:0]        wmask;
  logic [31:0]        rd_val;
  logic               unused_addr_bits;

  logic [PWM_W:0]     duty_sh [NUM_CH];
  logic [PWM_W:0]     duty_wd [NUM_CH];
  logic [NUM_CH-1:0]  duty_we;

  assign accept = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
  assign wr_acc = accept && (|iomem_wstrb);
  assign word   = iomem_addr[7:2];
  assign wmask  = lane_mask(iomem_wstrb);
  assign unused_addr_bits = ^{iomem_addr[23:8], iomem_addr[1:0]};

  always_comb begin
    rd_val = '0;
    case (word)
      REG_CTRL:  rd_val[CTRL_EN_BIT]   = en;
      REG_PRESC: rd_val[PRESC_W-1:0]   = presc;
      REG_GPIO:  rd_val[NUM_CH-1:0]    = gpio;
`ifdef IOMEM_PWM_POLARITY_EN
      REG_POL:   rd_val[NUM_CH-1:0]    = pol;
`endif
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (word == REG_DUTY0 + 6'(i))
            rd_val[PWM_W:0] = duty_sh[i];
      end
    endcase
  end

  // rdata captures the mux before any write in the same access lands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      en          <= 1'b0;
      presc       <= '0;
      gpio        <= '0;
`ifdef IOMEM_PWM_POLARITY_EN
      pol         <= '0;
`endif
    end else begin
      iomem_ready <= accept;
      iomem_rdata <= accept ? rd_val : '0;
      if (wr_acc) begin
        case (word)
          REG_CTRL:
            if (iomem_wstrb[CTRL_EN_BIT/8])
              en <= iomem_wdata[CTRL_EN_BIT];
          REG_PRESC:
            presc <= PRESC_W'((32'(presc) & ~wmask) | (iomem_wdata & wmask));
          REG_GPIO:
            gpio <= NUM_CH'((32'(gpio) & ~wmask) | (iomem_wdata & wmask));
`ifdef IOMEM_PWM_POLARITY_EN
          REG_POL:
            pol <= NUM_CH'((32'(pol) & ~wmask) | (iomem_wdata & wmask));
`endif
          default: ;
        endcase
      end
    end
  end

  // ">=" lets a lowered PRESC take effect next cycle instead of wrapping.
  assign tick = (presc_cnt >= presc);
  assign wrap = en && tick && (cnt == '1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_cnt <= '0;
      cnt       <= '0;
    end else if (!en) begin
      presc_cnt <= '0;
      cnt       <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
      cnt       <= cnt + 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign duty_we[i] = wr_acc && (word == REG_DUTY0 + 6'(i));
    assign duty_wd[i] = (PWM_W+1)'((32'(duty_sh[i]) & ~wmask) | (iomem_wdata & wmask));

    pwm_channel #(.PWM_W(PWM_W)) u_ch (
      .clk        (clk),
      .resetn     (resetn),
      .en         (en),
      .wrap       (wrap),
      .duty_we    (duty_we[i]),
      .duty_wdata (duty_wd[i]),
      .cnt        (cnt),
      .gpio       (gpio[i]),
`ifdef IOMEM_PWM_POLARITY_EN
      .pol        (pol[i]),
`endif
      .duty_sh    (duty_sh[i]),
      .pwm_out    (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_iomem_pwm_gpio.sv
// Self-checking bench for iomem_pwm_gpio (NUM_CH=4, PWM_W=8, PRESC_W=16).
// Honours IOMEM_PWM_POLARITY_EN to pick the expected POL behaviour.
module tb_iomem_pwm_gpio;

  localparam int         NUM_CH  = 4;
  localparam int         PWM_W   = 8;
  localparam int         PRESC_W = 16;
  localparam logic [7:0] BASE    = 8'h03;

  logic              clk;
  logic              resetn;
  logic              iomem_valid;
  logic              iomem_ready;
  logic [3:0]        iomem_wstrb;
  logic [31:0]       iomem_addr;
  logic [31:0]       iomem_wdata;
  logic [31:0]       iomem_rdata;
  logic [NUM_CH-1:0] pwm_out;

  int n_tests = 0;
  int n_fail  = 0;

  // PWM reference state: edges since EN rose, prescale, shadow and active duty.
  int   m_n, m_p, m_bad, m_first_n;
  int   m_sh  [NUM_CH];
  int   m_act [NUM_CH];
  logic [NUM_CH-1:0] m_first_got, m_first_exp;

  iomem_pwm_gpio #(
    .NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESC_W(PRESC_W), .BASE_ADDR(BASE)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .pwm_out     (pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (tests=%0d failed=%0d)", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] a(input int w);
    return {BASE, 16'h0000, 6'(w), 2'b00};
  endfunction

  function automatic logic [31:0] reg_mask(input int w);
    if (w == 0) return 32'h1;
    if (w == 1) return 32'hFFFF;
    if (w == 2) return 32'hF;
`ifdef IOMEM_PWM_POLARITY_EN
    if (w == 3) return 32'hF;
`endif
    if (w >= 4 && w < 4 + NUM_CH) return 32'h1FF;
    return 32'h0;
  endfunction

  function automatic logic [31:0] strb_bits(input logic [3:0] s);
    logic [31:0] m;
    m = 0;
    for (int b = 0; b < 4; b++)
      if (s[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  // Bounded bus access; an expired wait counts as a failed comparison.
  task automatic bus_access(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, output logic [31:0] rdata);
    bit ok;
    ok = 0;
    rdata = 0;
    iomem_valid = 1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wdata;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (iomem_ready) begin ok = 1; rdata = iomem_rdata; break; end
    end
    iomem_valid = 0; iomem_wstrb = 0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL bus_timeout: addr=%h got no ready, required ready within 8 cycles", addr);
    end
  endtask

  task automatic do_reset();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    @(posedge clk); #1;
  endtask

  // One clock of PWM mode, optionally landing a full-word DUTY write on this edge.
  task automatic pwm_step(input int wch, input int wval);
    logic [NUM_CH-1:0] exp_v;
    int c;
    if (wch >= 0) begin
      iomem_valid = 1; iomem_addr = a(4 + wch); iomem_wstrb = 4'hF; iomem_wdata = 32'(wval);
    end
    @(posedge clk);
    m_n++;
    c = ((m_n - 1) / (m_p + 1)) % 256;
    for (int i = 0; i < NUM_CH; i++) exp_v[i] = (c < m_act[i]);
    if ((m_n % (m_p + 1)) == 0 && ((m_n / (m_p + 1)) % 256) == 0)
      for (int i = 0; i < NUM_CH; i++) m_act[i] = m_sh[i];
    if (wch >= 0) m_sh[wch] = wval;
    #1;
    if (wch >= 0) begin
      iomem_valid = 0; iomem_wstrb = 0;
      if (iomem_ready !== 1'b1) m_bad++;
    end
    if (pwm_out !== exp_v) begin
      if (m_bad == 0) begin m_first_n = m_n; m_first_got = pwm_out; m_first_exp = exp_v; end
      m_bad++;
    end
  endtask

  task automatic pwm_start(input int p, input int d [NUM_CH]);
    logic [31:0] rd;
    bus_access(a(0), 4'hF, 0, rd);
    bus_access(a(1), 4'hF, 32'(p), rd);
    for (int i = 0; i < NUM_CH; i++) bus_access(a(4 + i), 4'hF, 32'(d[i]), rd);
    repeat (2) @(posedge clk);
    #1;
    m_p = p;
    for (int i = 0; i < NUM_CH; i++) begin m_sh[i] = d[i]; m_act[i] = d[i]; end
    bus_access(a(0), 4'hF, 1, rd);
    m_n = 0; m_bad = 0; m_first_n = 0;
  endtask

  task automatic check_model(input string name);
    n_tests++;
    if (m_bad !== 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad cycles, first at n=%0d got pwm_out=%b required %b",
               name, m_bad, m_first_n, m_first_got, m_first_exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int wl [6] = '{0, 1, 2, 3, 4, 16};
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (pwm_out !== 0 || iomem_ready !== 0 || iomem_rdata !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pwm=%b ready=%b rdata=%h required 0", pwm_out, iomem_ready, iomem_rdata);
    end
    resetn = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (iomem_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_ready: got %b required 0", iomem_ready);
      end
    end
    foreach (wl[j]) begin
      bus_access(a(wl[j]), 4'h0, 0, rd);
      n_tests++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg_%0d: got %h required 0", wl[j], rd);
      end
    end
  endtask

  task automatic test_regfile();
    logic [31:0] mreg [64];
    logic [31:0] rd, wd, lm;
    logic [3:0]  s;
    int opts [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 16, 63};
    int w;
    do_reset();
    for (int i = 0; i < 64; i++) mreg[i] = 0;
    for (int k = 0; k < 40; k++) begin
      w  = opts[$urandom_range(0, 10)];
      s  = 4'($urandom_range(0, 15));
      wd = $urandom;
      bus_access(a(w), s, wd, rd);
      n_tests++;
      if (rd !== mreg[w]) begin
        n_fail++;
        $display("FAIL regfile_prewrite w%0d: got %h required %h", w, rd, mreg[w]);
      end
      lm = strb_bits(s);
      mreg[w] = ((mreg[w] & ~lm) | (wd & lm)) & reg_mask(w);
    end
    foreach (opts[j]) begin
      bus_access(a(opts[j]), 4'h0, 0, rd);
      n_tests++;
      if (rd !== mreg[opts[j]]) begin
        n_fail++;
        $display("FAIL regfile_read w%0d: got %h required %h", opts[j], rd, mreg[opts[j]]);
      end
    end
  endtask

  task automatic test_strobe_decode();
    logic [31:0] rd;
    bit seen;
    do_reset();
    bus_access(a(2), 4'hF, 32'hF, rd);
    bus_access(a(2), 4'b0010, 32'hAABBCCDD, rd);
    bus_access(a(2), 4'h0, 0, rd);
    n_tests++;
    if (rd !== 32'hF) begin n_fail++; $display("FAIL gpio_strobe: got %h required %h", rd, 32'hF); end
    bus_access(a(1), 4'b0010, 32'hAABBCCDD, rd);
    bus_access(a(1), 4'h0, 0, rd);
    n_tests++;
    if (rd !== 32'hCC00) begin n_fail++; $display("FAIL presc_strobe: got %h required %h", rd, 32'hCC00); end
    bus_access(a(16), 4'h0, 0, rd);
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h required 0", rd); end
    seen = 0;
    iomem_valid = 1; iomem_addr = 32'h0400_0000; iomem_wstrb = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (iomem_ready) seen = 1;
    end
    iomem_valid = 0;
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL foreign_addr: got ready=1 required none"); end
  endtask

  task automatic test_gpio_mode();
    logic [31:0] rd;
    logic [3:0] g;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      g = 4'($urandom_range(0, 15));
      bus_access(a(2), 4'hF, {28'h0, g}, rd);
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (pwm_out !== g) begin n_fail++; $display("FAIL gpio_out: got %b required %b", pwm_out, g); end
    end
  endtask

  task automatic test_pwm_basic();
    int hi, d3;
    bit ch1_hi, ch2_lo;
    do_reset();
    d3 = $urandom_range(0, 511);
    pwm_start(0, '{64, 0, 256, d3});
    hi = 0; ch1_hi = 0; ch2_lo = 0;
    while (m_n < 768) begin
      pwm_step(-1, 0);
      if (m_n <= 256) hi += int'(pwm_out[0]);
      if (pwm_out[1]) ch1_hi = 1;
      if (!pwm_out[2]) ch2_lo = 1;
    end
    n_tests++;
    if (hi !== 64) begin n_fail++; $display("FAIL high_time_p0: got %0d required 64", hi); end
    n_tests++;
    if (ch1_hi !== 1'b0) begin n_fail++; $display("FAIL duty0_const_low: got a high cycle required none"); end
    n_tests++;
    if (ch2_lo !== 1'b0) begin n_fail++; $display("FAIL duty256_const_high: got a low cycle required none"); end
    check_model("pwm_p0_model");

    pwm_start(3, '{64, $urandom_range(0, 300), $urandom_range(0, 300), $urandom_range(0, 300)});
    hi = 0;
    while (m_n < 2048) begin
      pwm_step(-1, 0);
      if (m_n <= 1024) hi += int'(pwm_out[0]);
    end
    n_tests++;
    if (hi !== 256) begin n_fail++; $display("FAIL high_time_p3: got %0d required 256", hi); end
    check_model("pwm_p3_model");
  endtask

  task automatic test_duty_update();
    int hi;
    do_reset();
    pwm_start(0, '{64, 128, 200, 10});
    while (m_n < 100) pwm_step(-1, 0);
    pwm_step(0, 192);
    hi = 0;
    while (m_n < 256) begin pwm_step(-1, 0); hi += int'(pwm_out[0]); end
    n_tests++;
    if (hi !== 0) begin n_fail++; $display("FAIL rest_of_period: got %0d high required 0", hi); end
    hi = 0;
    while (m_n < 512) begin pwm_step(-1, 0); hi += int'(pwm_out[0]); end
    n_tests++;
    if (hi !== 192) begin n_fail++; $display("FAIL next_period: got %0d high required 192", hi); end
    while (m_n < 767) pwm_step(-1, 0);
    pwm_step(0, 32);
    hi = 0;
    while (m_n < 1024) begin pwm_step(-1, 0); hi += int'(pwm_out[0]); end
    n_tests++;
    if (hi !== 192) begin n_fail++; $display("FAIL wrap_write_deferred: got %0d high required 192", hi); end
    hi = 0;
    while (m_n < 1280) begin pwm_step(-1, 0); hi += int'(pwm_out[0]); end
    n_tests++;
    if (hi !== 32) begin n_fail++; $display("FAIL wrap_write_applied: got %0d high required 32", hi); end
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(2, 120)) pwm_step(-1, 0);
      pwm_step($urandom_range(0, NUM_CH - 1), $urandom_range(0, 511));
    end
    repeat (600) pwm_step(-1, 0);
    check_model("duty_update_model");
  endtask

  task automatic test_polarity();
    logic [31:0] rd;
    do_reset();
    bus_access(a(3), 4'hF, 32'h1, rd);
    bus_access(a(2), 4'hF, 32'h0, rd);
    repeat (2) @(posedge clk);
    #1;
`ifdef IOMEM_PWM_POLARITY_EN
    n_tests++;
    if (pwm_out !== 4'b0001) begin n_fail++; $display("FAIL pol_gpio: got %b required 0001", pwm_out); end
    bus_access(a(3), 4'h0, 0, rd);
    n_tests++;
    if (rd !== 32'h1) begin n_fail++; $display("FAIL pol_read: got %h required 1", rd); end
`else
    bus_access(a(3), 4'hF, 32'hF, rd);
    bus_access(a(3), 4'h0, 0, rd);
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL pol_absent_read: got %h required 0", rd); end
    n_tests++;
    if (pwm_out !== 4'b0000) begin n_fail++; $display("FAIL pol_absent_out: got %b required 0000", pwm_out); end
`endif
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    do_reset();
    bus_access(a(4), 4'hF, 32'd256, rd);
    bus_access(a(0), 4'hF, 32'h1, rd);
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (pwm_out[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_high: got %b required 1", pwm_out[0]); end
    @(posedge clk);
    #3 resetn = 0;
    #1;
    n_tests++;
    if (pwm_out !== 0 || iomem_ready !== 0) begin
      n_fail++;
      $display("FAIL async_reset: got pwm=%b ready=%b required 0", pwm_out, iomem_ready);
    end
    @(posedge clk);
    #1 resetn = 1;
    bus_access(a(0), 4'h0, 0, rd);
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL post_reset_ctrl: got %h required 0", rd); end
  endtask

  initial begin
    clk = 0; resetn = 0;
    iomem_valid = 0; iomem_wstrb = 0; iomem_addr = 0; iomem_wdata = 0;
    test_reset();
    test_regfile();
    test_strobe_decode();
    test_gpio_mode();
    test_pwm_basic();
    test_duty_update();
    test_polarity();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iomem_pwm_gpio.md
# iomem_pwm_gpio

Parametrised memory-mapped LED/GPIO peripheral for the ricosoc `iomem` bus. It replaces the fixed 32-bit GPIO register in board tops with:
- a plain GPIO output register;
- `NUM_CH` PWM channels with double-buffered duty registers and a shared prescaler;
- an optional per-channel polarity inversion for active-low RGB LEDs.

It sits between the SoC `iomem` port and the board pins.

## Interface
Parameters:
- `NUM_CH`, 4: number of output channels, 1..32.
- `PWM_W`, 8: PWM counter width; period is 2^PWM_W ticks.
- `PRESC_W`, 16: prescaler width.
- `BASE_ADDR`, 8'h03: decoded against `iomem_addr[31:24]`.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: reset. One clock; reset is asynchronous and active-low.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: one-cycle acknowledge.
- `iomem_wstrb` in 4: byte write strobes; 0 means read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready`=1.
- `pwm_out` out NUM_CH: registered channel outputs.

## Operation
Register map. Word offset is `iomem_addr[7:2]`, shown here as byte offsets:
- 0x00 CTRL: bit0 EN.
- 0x04 PRESC: `PRESC_W` bits.
- 0x08 GPIO: `NUM_CH` bits, direct output value when EN=0.
- 0x0C POL: `NUM_CH` bits; exists only with the macro, see Configuration.
- 0x10+4·i DUTY[i]: `PWM_W+1` bits, i < NUM_CH.

Bus access:
- A request is accepted when `iomem_valid` && !`iomem_ready` && `iomem_addr[31:24]`==`BASE_ADDR`.
- Writes honour `iomem_wstrb` per byte lane; bits beyond a register's width are ignored on write and read as 0.
- Unmapped offsets read 0; writes to them are dropped.
- Non-matching addresses get no `iomem_ready`.

Prescaler and counter:
- `presc_cnt` increments every clock.
- When `presc_cnt` >= PRESC, `presc_cnt` returns to 0 and a tick is issued.
- On each tick, `cnt` (`PWM_W` bits) increments, wrapping from 2^PWM_W−1 to 0.
- The ">=" comparison means lowering PRESC below the current `presc_cnt` ticks on the next cycle rather than wrapping through 2^PRESC_W.

Duty buffering:
- A DUTY write lands in `duty_sh[i]`.
- `duty_act[i]` <= `duty_sh[i]` on the tick that wraps `cnt` to 0.
- A DUTY write in the same cycle as a wrap tick is captured in shadow only; the active register takes the old shadow, and the new value applies from the following wrap.

EN=0:
- `cnt`=0 and `presc_cnt`=0.
- `duty_act` tracks `duty_sh` every cycle.
- `pwm_out` <= GPIO ^ POL.

EN=1:
- `pwm_out[i]` <= (`cnt` < `duty_act[i]`) ^ POL[i], compared unsigned at width `PWM_W+1`.
- DUTY=0 gives constant low; DUTY >= 2^PWM_W gives constant high.
- A 0→1 transition of EN starts at `cnt`=0 with `duty_act` already equal to the shadow.

Reset values: all registers 0, `cnt`=0, `presc_cnt`=0, `pwm_out`=0, `iomem_ready`=0, `iomem_rdata`=0. Asserting reset mid-period clears everything immediately and asynchronously.

## Timing
- `iomem_ready` rises exactly 1 cycle after an accepted request, lasts 1 cycle, then is low for at least 1 cycle.
- `iomem_rdata` is registered with `iomem_ready`. It returns the pre-write value when the access is also a write.
- A register write is visible in `pwm_out` on the second clock after `iomem_ready` (EN/GPIO/POL paths).
- `pwm_out` lags `cnt` by 1 cycle.
- PWM period = (PRESC+1)·2^PWM_W clocks; high time = DUTY·(PRESC+1) clocks.

## Configuration
- Macro `IOMEM_PWM_POLARITY_EN`.
- Defined: POL at 0x0C is read/write and XORs every `pwm_out` bit, in both GPIO and PWM mode.
- Undefined: POL is not implemented, 0x0C reads 0, writes are ignored, and no XOR logic is present.

## Structure
- Package `iomem_pwm_pkg` holds:
  - register offset constants (`REG_CTRL`, `REG_PRESC`, `REG_GPIO`, `REG_POL`, `REG_DUTY0`);
  - the CTRL EN bit index;
  - the `NUM_CH` upper-limit constant.
- Sub-module `pwm_channel`, instantiated `NUM_CH` times, holds one channel:
  - `duty_sh`/`duty_act` registers;
  - shadow load on wrap or EN=0;
  - compare;
  - polarity XOR;
  - output register.
- Top level holds:
  - bus decode;
  - CTRL/PRESC/GPIO/POL registers;
  - prescaler;
  - counter.

## Test plan
1. Release reset → every register reads 0, `pwm_out`=0, `iomem_ready` low with `iomem_valid`=0.
2. NUM_CH=4, PWM_W=8, PRESC=0, DUTY0=64, EN=1 → `pwm_out[0]` high for 64 of every 256 clocks, period 256; PRESC=3 → period 1024, high 256.
3. DUTY0=0 → constant low; DUTY0=256 → constant high across several periods.
4. DUTY0 changes from 64 to 192 while `cnt`=100 → remainder of the current period stays low; the next period is high for 192 ticks. A DUTY write coinciding with the wrap tick applies one period later.
5. Write 0xAABBCCDD to GPIO with wstrb=4'b0010 → only byte 1 updated (masked to NUM_CH bits). Access to 0x0400_0000 → no `iomem_ready` within 4 cycles. Unmapped offset 0x40 → reads 0.
6. With `IOMEM_PWM_POLARITY_EN`, POL=0x1 and EN=0, GPIO=0 → `pwm_out[0]`=1. Without the macro, POL reads 0 after writing 0xF. Async reset asserted mid-period → `pwm_out`=0 immediately.
